arrival_time_spi_slave: RTL and testbench

SPI mode-0 slave that lets the external MBED microcontroller read ultrasonic arrival-time results from the FPGA. The ultrasonic receiver channels push 10-bit arrival times into a small internal FIFO. The MBED, acting as SPI master, clocks 16-bit frames out of the block and sends a 16-bit command word back on MOSI in the same frame. The block sits beside the receiver instances in the top level, on GPIO_1.

---
 rtl/arrival_time_spi_slave_if.sv | 30 +++
 rtl/arrival_time_spi_slave.sv | 232 +++++++++++++++++++++++
 tb/tb_arrival_time_spi_slave.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/arrival_time_spi_slave_if.sv
// Bundled pins of the arrival-time SPI slave: sample write port, SPI pins and status.
// The slave modport is the block's view; the master modport is the view of whatever drives it.
interface arrival_time_spi_slave_if #(
    parameter int DATA_BITS = 10,
    parameter int FIFO_AW   = 2
);
    logic                 ON;
    logic [DATA_BITS-1:0] WR_DATA;
    logic [1:0]           WR_CHAN;
    logic                 WR_EN;
    logic                 SCK;
    logic                 MOSI;
    logic                 CSbar;
    logic                 MISO;
    logic                 MISO_OE;
    logic [15:0]          RX_WORD;
    logic                 RX_VALID;
    logic [FIFO_AW:0]     FIFO_COUNT;
    logic                 OVERFLOW;

    modport slave (
        input  ON, WR_DATA, WR_CHAN, WR_EN, SCK, MOSI, CSbar,
        output MISO, MISO_OE, RX_WORD, RX_VALID, FIFO_COUNT, OVERFLOW
    );

    modport master (
        output ON, WR_DATA, WR_CHAN, WR_EN, SCK, MOSI, CSbar,
        input  MISO, MISO_OE, RX_WORD, RX_VALID, FIFO_COUNT, OVERFLOW
    );
endinterface

// File: rtl/arrival_time_spi_slave.sv
// SPI mode-0 slave: queues tagged ultrasonic arrival times and shifts them out to the MBED
// as 16-bit frames, capturing the MBED's 16-bit command word on MOSI in the same frame.
module arrival_time_spi_slave #(
    parameter int DATA_BITS  = 10,
    parameter int FIFO_AW    = 2,
    parameter int FRAME_BITS = 16
) (
    input logic                    SYS_CLK,
    input logic                    RST,
    arrival_time_spi_slave_if.slave bus
);
    localparam int               DEPTH     = 2 ** FIFO_AW;
    localparam int               LOW_BITS  = FRAME_BITS - 4;
    localparam logic [FIFO_AW:0] DEPTH_CNT = (FIFO_AW + 1)'(DEPTH);
    localparam logic [4:0]       FRAME_LEN = 5'(FRAME_BITS);
    localparam logic [4:0]       CNT_MAX   = 5'(FRAME_BITS + 1);
    localparam logic [7:0]       CMD_CLR   = 8'hA5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic [2:0]          sck_sync_r;
    logic [2:0]          cs_sync_r;
    logic [1:0]          mosi_sync_r;
    logic                sck_rise_s;
    logic                sck_fall_s;
    logic                cs_fall_s;
    logic                cs_rise_s;
    logic                mosi_s;
    logic [13:0]         mem_r [DEPTH];
    logic [FIFO_AW-1:0]  wr_ptr_r;
    logic [FIFO_AW-1:0]  rd_ptr_r;
    logic [FIFO_AW:0]    count_r;
    logic                overflow_r;
    logic                full_s;
    logic                empty_s;
    logic                push_s;
    logic                pop_s;
    logic                drop_s;
    logic                frame_ok_s;
    logic                cmd_clr_s;
    logic [15:0]         head_word_s;
    logic [14:0]         tx_r;
    logic                tx_valid_r;
    logic [15:0]         rx_r;
    logic [15:0]         rx_word_r;
    logic                rx_valid_r;
    logic [4:0]          bit_cnt_r;
    logic                miso_r;
    logic                miso_oe_r;

    assign sck_rise_s = sck_sync_r[1] & ~sck_sync_r[2];
    assign sck_fall_s = ~sck_sync_r[1] & sck_sync_r[2];
    assign cs_fall_s  = ~cs_sync_r[1] & cs_sync_r[2];
    assign cs_rise_s  = cs_sync_r[1] & ~cs_sync_r[2];
    assign mosi_s     = mosi_sync_r[1];

    assign bus.MISO       = miso_r;
    assign bus.MISO_OE    = miso_oe_r;
    assign bus.RX_WORD    = rx_word_r;
    assign bus.RX_VALID   = rx_valid_r;
    assign bus.FIFO_COUNT = count_r;
    assign bus.OVERFLOW   = overflow_r;

    // Synchronise SPI pins; the CSbar chain resets low so a CSbar held low through reset is not a new frame.
    always_ff @(posedge SYS_CLK or negedge RST) begin
        if (!RST) begin
            sck_sync_r  <= 3'b000;
            cs_sync_r   <= 3'b000;
            mosi_sync_r <= 2'b00;
        end else begin
            sck_sync_r  <= {sck_sync_r[1:0], bus.SCK};
            cs_sync_r   <= {cs_sync_r[1:0], bus.CSbar};
            mosi_sync_r <= {mosi_sync_r[0], bus.MOSI};
        end
    end

    // Frame state register.
    always_ff @(posedge SYS_CLK or negedge RST) begin
        if (!RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; disabling the block abandons any frame in flight.
    always_comb begin
        state_next_s = state_r;
        if (!bus.ON) begin
            state_next_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (cs_fall_s) begin
                        state_next_s = ACTIVE;
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                ACTIVE: begin
                    if (cs_rise_s) begin
                        state_next_s = DONE;
                    end else begin
                        state_next_s = ACTIVE;
                    end
                end
                DONE:    state_next_s = IDLE;
                default: state_next_s = IDLE;
            endcase
        end
    end

    // FIFO control: a write into a full FIFO still lands if the head is popped that same cycle.
    always_comb begin
        full_s     = (count_r == DEPTH_CNT);
        empty_s    = (count_r == {(FIFO_AW + 1){1'b0}});
        frame_ok_s = bus.ON && (state_r == DONE) && (bit_cnt_r == FRAME_LEN);
        pop_s      = frame_ok_s && tx_valid_r && !empty_s;
        push_s     = bus.ON && bus.WR_EN && (!full_s || pop_s);
        drop_s     = bus.ON && bus.WR_EN && full_s && !pop_s;
        cmd_clr_s  = frame_ok_s && (rx_r[15:8] == CMD_CLR);
        if (empty_s) begin
            head_word_s = {1'b0, overflow_r, 14'b0};
        end else begin
            head_word_s = {1'b1, overflow_r, mem_r[rd_ptr_r]};
        end
    end

    // Sample storage; contents only matter while counted as occupied.
    always_ff @(posedge SYS_CLK) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {bus.WR_CHAN, LOW_BITS'(bus.WR_DATA)};
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag (a drop outranks the clear command).
    always_ff @(posedge SYS_CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr_r   <= {FIFO_AW{1'b0}};
            rd_ptr_r   <= {FIFO_AW{1'b0}};
            count_r    <= {(FIFO_AW + 1){1'b0}};
            overflow_r <= 1'b0;
        end else if (!bus.ON) begin
            wr_ptr_r   <= {FIFO_AW{1'b0}};
            rd_ptr_r   <= {FIFO_AW{1'b0}};
            count_r    <= {(FIFO_AW + 1){1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (cmd_clr_s) begin
                overflow_r <= 1'b0;
            end
        end
    end

    // Shift datapath: snapshot at frame start, capture MOSI on SCK rise, advance MISO on SCK fall.
    always_ff @(posedge SYS_CLK or negedge RST) begin
        if (!RST) begin
            tx_r       <= 15'b0;
            tx_valid_r <= 1'b0;
            rx_r       <= 16'b0;
            rx_word_r  <= 16'b0;
            rx_valid_r <= 1'b0;
            bit_cnt_r  <= 5'd0;
            miso_r     <= 1'b0;
            miso_oe_r  <= 1'b0;
        end else begin
            rx_valid_r <= 1'b0;
            if (!bus.ON) begin
                tx_valid_r <= 1'b0;
                bit_cnt_r  <= 5'd0;
                miso_r     <= 1'b0;
                miso_oe_r  <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        bit_cnt_r <= 5'd0;
                        if (cs_fall_s) begin
                            tx_r       <= head_word_s[14:0];
                            tx_valid_r <= head_word_s[15];
                            rx_r       <= 16'b0;
                            miso_r     <= head_word_s[15];
                            miso_oe_r  <= 1'b1;
                        end
                    end
                    ACTIVE: begin
                        if (sck_rise_s) begin
                            rx_r <= {rx_r[14:0], mosi_s};
                            if (bit_cnt_r != CNT_MAX) begin
                                bit_cnt_r <= bit_cnt_r + 5'd1;
                            end
                        end
                        if (sck_fall_s) begin
                            miso_r <= tx_r[14];
                            tx_r   <= {tx_r[13:0], 1'b0};
                        end
                    end
                    DONE: begin
                        if (frame_ok_s) begin
                            rx_word_r  <= rx_r;
                            rx_valid_r <= 1'b1;
                        end
                        miso_r    <= 1'b0;
                        miso_oe_r <= 1'b0;
                    end
                    default: begin
                        miso_r    <= 1'b0;
                        miso_oe_r <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_arrival_time_spi_slave.sv
// Directed bench for arrival_time_spi_slave: a vector table of write/frame steps plus
// hand sequences for the pop-with-write, enable-drop and mid-frame reset corners.
module tb_arrival_time_spi_slave;
    logic clk = 1'b0;
    logic rst_n;
    int   total  = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    arrival_time_spi_slave_if #(.DATA_BITS(10), .FIFO_AW(2)) bus ();

    arrival_time_spi_slave #(.DATA_BITS(10), .FIFO_AW(2), .FRAME_BITS(16)) dut (
        .SYS_CLK (clk),
        .RST     (rst_n),
        .bus     (bus)
    );

    typedef struct {
        bit          do_wr;
        logic [9:0]  wdata;
        logic [1:0]  wchan;
        logic [2:0]  exp_pre;
        int          nbits;
        logic [15:0] mosi;
        logic [15:0] exp_miso;
        int          exp_rxv;
        logic [15:0] exp_rx;
        logic [2:0]  exp_cnt;
        logic        exp_ovf;
    } vec_t;

    vec_t        vecs [15];
    logic [15:0] miso_w;
    int          rxv;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [9:0] d, input logic [1:0] ch);
        bus.WR_DATA = d;
        bus.WR_CHAN = ch;
        bus.WR_EN   = 1'b1;
        tick(1);
        bus.WR_EN   = 1'b0;
    endtask

    // SCK = SYS_CLK/8; MISO is sampled as the master would, on SCK rising.
    // With inject set, WR_EN is strobed so that it lands on the end-of-frame pop edge.
    task automatic frame(input logic [15:0] mw, input int nbits, input bit inject,
                         output logic [15:0] sw, output int nrxv);
        sw   = 16'h0000;
        nrxv = 0;
        bus.CSbar = 1'b0;
        tick(4);
        for (int i = 0; i < nbits; i++) begin
            bus.MOSI = (i < 16) ? mw[15 - i] : 1'b0;
            tick(4);
            bus.SCK = 1'b1;
            if (i < 16) sw[15 - i] = bus.MISO;
            tick(4);
            bus.SCK = 1'b0;
        end
        tick(4);
        bus.CSbar = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            if (bus.RX_VALID === 1'b1) nrxv++;
            bus.WR_EN = inject && (k == 3);
        end
        bus.WR_EN = 1'b0;
        bus.MOSI  = 1'b0;
    endtask

    function automatic logic [31:0] all_out();
        return {9'b0, bus.MISO, bus.MISO_OE, bus.RX_WORD, bus.RX_VALID, bus.FIFO_COUNT, bus.OVERFLOW};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //         wr    data     ch    pre   nb  mosi      miso      rxv rx        cnt   ovf
        vecs[0]  = '{1'b1, 10'h155, 2'd2, 3'd1, 16, 16'h0000, 16'hA155, 1, 16'h0000, 3'd0, 1'b0};
        vecs[1]  = '{1'b0, 10'h000, 2'd0, 3'd0, 16, 16'h1234, 16'h0000, 1, 16'h1234, 3'd0, 1'b0};
        vecs[2]  = '{1'b1, 10'h001, 2'd0, 3'd1, 0,  16'h0000, 16'h0000, 0, 16'h0000, 3'd1, 1'b0};
        vecs[3]  = '{1'b1, 10'h002, 2'd0, 3'd2, 0,  16'h0000, 16'h0000, 0, 16'h0000, 3'd2, 1'b0};
        vecs[4]  = '{1'b1, 10'h003, 2'd0, 3'd3, 0,  16'h0000, 16'h0000, 0, 16'h0000, 3'd3, 1'b0};
        vecs[5]  = '{1'b1, 10'h004, 2'd0, 3'd4, 0,  16'h0000, 16'h0000, 0, 16'h0000, 3'd4, 1'b0};
        vecs[6]  = '{1'b1, 10'h005, 2'd0, 3'd4, 0,  16'h0000, 16'h0000, 0, 16'h0000, 3'd4, 1'b1};
        vecs[7]  = '{1'b0, 10'h000, 2'd0, 3'd0, 16, 16'h0000, 16'hC001, 1, 16'h0000, 3'd3, 1'b1};
        vecs[8]  = '{1'b0, 10'h000, 2'd0, 3'd0, 16, 16'h0000, 16'hC002, 1, 16'h0000, 3'd2, 1'b1};
        vecs[9]  = '{1'b0, 10'h000, 2'd0, 3'd0, 16, 16'h0000, 16'hC003, 1, 16'h0000, 3'd1, 1'b1};
        vecs[10] = '{1'b0, 10'h000, 2'd0, 3'd0, 16, 16'h0000, 16'hC004, 1, 16'h0000, 3'd0, 1'b1};
        vecs[11] = '{1'b0, 10'h000, 2'd0, 3'd0, 16, 16'hA500, 16'h4000, 1, 16'hA500, 3'd0, 1'b0};
        vecs[12] = '{1'b1, 10'h2AA, 2'd0, 3'd1, 9,  16'hFFFF, 16'h0000, 0, 16'hA500, 3'd1, 1'b0};
        vecs[13] = '{1'b0, 10'h000, 2'd0, 3'd0, 17, 16'hFFFF, 16'h0000, 0, 16'hA500, 3'd1, 1'b0};
        vecs[14] = '{1'b0, 10'h000, 2'd0, 3'd0, 16, 16'h5A5A, 16'h82AA, 1, 16'h5A5A, 3'd0, 1'b0};

        rst_n       = 1'b0;
        bus.ON      = 1'b1;
        bus.WR_DATA = 10'h000;
        bus.WR_CHAN = 2'd0;
        bus.WR_EN   = 1'b0;
        bus.SCK     = 1'b0;
        bus.MOSI    = 1'b0;
        bus.CSbar   = 1'b1;
        tick(3);
        check("reset outputs", all_out(), 32'h0);
        rst_n = 1'b1;
        tick(5);
        check("idle after reset", all_out(), 32'h0);

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].do_wr) begin
                wr(vecs[i].wdata, vecs[i].wchan);
                check($sformatf("v%0d count after write", i), bus.FIFO_COUNT, vecs[i].exp_pre);
            end
            if (vecs[i].nbits > 0) begin
                frame(vecs[i].mosi, vecs[i].nbits, 1'b0, miso_w, rxv);
                if (vecs[i].nbits == 16) check($sformatf("v%0d miso word", i), miso_w, vecs[i].exp_miso);
                check($sformatf("v%0d rx_valid pulses", i), rxv, vecs[i].exp_rxv);
                check($sformatf("v%0d rx_word", i), bus.RX_WORD, vecs[i].exp_rx);
            end
            check($sformatf("v%0d fifo_count", i), bus.FIFO_COUNT, vecs[i].exp_cnt);
            check($sformatf("v%0d overflow", i), bus.OVERFLOW, vecs[i].exp_ovf);
        end

        // Write landing on the pop edge with the FIFO full: accepted, no overflow.
        for (int i = 0; i < 4; i++) wr(10'h010 + 10'(i), 2'd1);
        check("full before pop", bus.FIFO_COUNT, 3'd4);
        bus.WR_DATA = 10'h020;
        bus.WR_CHAN = 2'd3;
        frame(16'h0000, 16, 1'b1, miso_w, rxv);
        check("pop+write miso", miso_w, 16'h9010);
        check("pop+write rx_valid", rxv, 1);
        check("pop+write count", bus.FIFO_COUNT, 3'd4);
        check("pop+write overflow", bus.OVERFLOW, 1'b0);
        frame(16'hBEEF, 16, 1'b0, miso_w, rxv);
        check("next head miso", miso_w, 16'h9011);
        check("next head count", bus.FIFO_COUNT, 3'd3);
        check("next head rx_word", bus.RX_WORD, 16'hBEEF);

        // Enable dropped mid-frame with three entries queued.
        bus.CSbar = 1'b0;
        tick(4);
        for (int i = 0; i < 5; i++) begin
            bus.MOSI = 1'b1;
            tick(4);
            bus.SCK = 1'b1;
            tick(4);
            bus.SCK = 1'b0;
        end
        check("oe during frame", bus.MISO_OE, 1'b1);
        bus.ON = 1'b0;
        tick(1);
        check("on low miso_oe", bus.MISO_OE, 1'b0);
        check("on low miso", bus.MISO, 1'b0);
        check("on low count", bus.FIFO_COUNT, 3'd0);
        wr(10'h3FF, 2'd0);
        check("on low write ignored", bus.FIFO_COUNT, 3'd0);
        bus.CSbar = 1'b1;
        rxv = 0;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            if (bus.RX_VALID === 1'b1) rxv++;
        end
        check("on low no rx_valid", rxv, 0);
        bus.ON   = 1'b1;
        bus.MOSI = 1'b0;
        tick(4);
        check("on restored idle", all_out(), {9'b0, 2'b00, 16'hBEEF, 1'b0, 3'd0, 1'b0});

        // Reset asserted mid-frame.
        wr(10'h100, 2'd0);
        bus.CSbar = 1'b0;
        tick(4);
        for (int i = 0; i < 2; i++) begin
            tick(4);
            bus.SCK = 1'b1;
            tick(4);
            bus.SCK = 1'b0;
        end
        check("oe before reset", bus.MISO_OE, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset outputs", all_out(), 32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(10);
        check("no frame without new cs fall", bus.MISO_OE, 1'b0);
        bus.CSbar = 1'b1;
        tick(6);
        frame(16'h0F0F, 16, 1'b0, miso_w, rxv);
        check("post reset miso", miso_w, 16'h0000);
        check("post reset rx_valid", rxv, 1);
        check("post reset rx_word", bus.RX_WORD, 16'h0F0F);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
